// File: rtl/cache_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a single-port cache_and_ram.
// Optional completed-access counters are built only when CACHE_ARB_STATS_EN is defined.
module cache_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_mode,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_data,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W-1:0]     mem_data,
    output logic                  mem_mode,
    input  logic [DATA_W-1:0]     mem_out,
    output logic [15:0]           stat_cnt0,
    output logic [15:0]           stat_cnt1
);

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_owner;
    logic                r_last_owner;
    logic [1:0]          r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [DATA_W-1:0]   r_mem_data;
    logic                r_mem_mode;

    logic [1:0]          w_grant;
    logic                w_sel;
    logic                w_accept;
    logic                w_done;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic                w_mode;

    // On a tie the requester that did not own the previous access wins.
    always_comb begin
        w_grant = req_valid;
        if (req_valid == 2'b11) begin
            w_grant = r_last_owner ? 2'b01 : 2'b10;
        end
    end

    assign w_sel    = w_grant[1];
    assign w_accept = (r_state == S_IDLE) && (w_grant != 2'b00);
    assign w_done   = (r_state == S_BUSY) && (r_cnt == 4'd1);
    assign w_addr   = w_sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign w_data   = w_sel ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
    assign w_mode   = w_sel ? req_mode[1] : req_mode[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_BUSY;
            S_BUSY:  if (r_cnt == 4'd1) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (r_state == S_IDLE) begin
            req_ready = w_grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= 4'd0;
            r_owner       <= 1'b0;
            r_last_owner  <= 1'b1;
            r_rsp_valid   <= 2'b00;
            r_rsp_data    <= '0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_mode    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem_address <= w_addr;
                r_mem_data    <= w_data;
                r_mem_mode    <= w_mode;
                r_owner       <= w_sel;
                r_last_owner  <= w_sel;
                r_cnt         <= LAT;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
                // Writes echo their own data; mode falls back to read so the write is not repeated.
                if (w_done) begin
                    r_rsp_data  <= r_mem_mode ? r_mem_data : mem_out;
                    r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                    r_mem_mode  <= 1'b0;
                end
            end else if (r_state == S_RESP) begin
                r_rsp_valid <= 2'b00;
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign mem_address = r_mem_address;
    assign mem_data    = r_mem_data;
    assign mem_mode    = r_mem_mode;

`ifdef CACHE_ARB_STATS_EN
    logic [15:0] r_stat0;
    logic [15:0] r_stat1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat0 <= 16'd0;
            r_stat1 <= 16'd0;
        end else begin
            if (r_rsp_valid[0]) r_stat0 <= r_stat0 + 16'd1;
            if (r_rsp_valid[1]) r_stat1 <= r_stat1 + 16'd1;
        end
    end

    assign stat_cnt0 = r_stat0;
    assign stat_cnt1 = r_stat1;
`else
    assign stat_cnt0 = 16'd0;
    assign stat_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter with a behavioural memory and a transaction-level model.
module tb_cache_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
`ifdef CACHE_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_mode = 2'b00;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_data = '0;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_data;
    logic            mem_mode;
    logic [DW-1:0]   mem_out;
    logic [15:0]     stat_cnt0;
    logic [15:0]     stat_cnt1;

    cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_mode(req_mode), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_address(mem_address), .mem_data(mem_data), .mem_mode(mem_mode), .mem_out(mem_out),
        .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for cache_and_ram: 4096 words, synchronous write, combinational read.
    logic [DW-1:0] mem [0:4095];
    bit            mem_init = 1'b0;
    assign mem_out = mem[mem_address[11:0]];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int k = 0; k < 4096; k++) mem[k] <= '0;
            mem_init <= 1'b1;
        end else if (mem_mode) begin
            mem[mem_address[11:0]] <= mem_data;
        end
    end

    logic [DW-1:0] refmem [0:4095];
    int errors = 0;
    int checks = 0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one request and reports what was observed; callers do the checking.
    task automatic access(input int i, input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int acc_n, output int rsp_n, output logic [DW-1:0] rd,
                          output logic mode_busy, output logic [AW-1:0] addr_busy,
                          output logic mode_resp, output logic rv_after);
        acc_n = -1; rsp_n = -1; rd = '0; mode_busy = 1'b0; addr_busy = '0;
        mode_resp = 1'b1; rv_after = 1'b1;
        @(negedge clk);
        req_mode[i] = m;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
        req_valid[i] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (req_ready[i]) begin
                acc_n = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid[i] = 1'b0;
        if (acc_n < 0) return;
        if (m) refmem[a[11:0]] = d;
        mode_busy = mem_mode;
        addr_busy = mem_address;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid[i]) begin
                rsp_n = cyc;
                rd = rsp_data;
                mode_resp = mem_mode;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        rv_after = rsp_valid[i];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        checks++; if (mem_address !== '0 || mem_data !== '0 || mem_mode !== 1'b0) begin
            errors++; $display("FAIL reset_mem: got addr=%h data=%h mode=%b expected 0/0/0", mem_address, mem_data, mem_mode); end
        checks++; if (stat_cnt0 !== 16'd0 || stat_cnt1 !== 16'd0) begin
            errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_cnt0, stat_cnt1); end
        rst = 1'b0;
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_tie: got %b expected 01", req_ready); end
        req_valid = 2'b00;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL ready_idle_novalid: got %b expected 00", req_ready); end
    endtask

    task automatic test_write_read();
        int a, r; logic [DW-1:0] rd; logic mb, mr, ra; logic [AW-1:0] ab;
        access(0, 1'b1, 32'd0, 32'd14528, a, r, rd, mb, ab, mr, ra);
        checks++; if (a < 0 || r < 0) begin errors++; $display("FAIL wr_handshake: got acc=%0d rsp=%0d expected both >=0", a, r); end
        checks++; if (r - a !== LAT + 1) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", r - a, LAT + 1); end
        checks++; if (rd !== 32'd14528) begin errors++; $display("FAIL wr_echo: got %0d expected 14528", rd); end
        checks++; if (mb !== 1'b1 || mr !== 1'b0) begin errors++; $display("FAIL wr_mode: got busy=%b resp=%b expected 1/0", mb, mr); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL wr_rsp_one_cycle: got %b expected 0", ra); end
        access(0, 1'b0, 32'd0, 32'd0, a, r, rd, mb, ab, mr, ra);
        checks++; if (r - a !== LAT + 1) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", r - a, LAT + 1); end
        checks++; if (rd !== 32'd14528) begin errors++; $display("FAIL rd_data: got %0d expected 14528", rd); end
        checks++; if (mb !== 1'b0) begin errors++; $display("FAIL rd_mode: got %b expected 0", mb); end
    endtask

    task automatic test_wide_addr();
        int a, r; logic [DW-1:0] rd; logic mb, mr, ra; logic [AW-1:0] ab;
        access(1, 1'b1, 32'd2816867292, 32'd526421, a, r, rd, mb, ab, mr, ra);
        checks++; if (ab !== 32'd2816867292) begin errors++; $display("FAIL wide_addr_wr: got %0d expected 2816867292", ab); end
        access(1, 1'b0, 32'd2816867292, 32'd0, a, r, rd, mb, ab, mr, ra);
        checks++; if (ab !== 32'd2816867292) begin errors++; $display("FAIL wide_addr_rd: got %0d expected 2816867292", ab); end
        checks++; if (rd !== 32'd526421) begin errors++; $display("FAIL wide_rd_data: got %0d expected 526421", rd); end
    endtask

    task automatic test_simultaneous();
        int a0, r0, a1, r1; logic [DW-1:0] d0, d1; logic mb0, mr0, ra0, mb1, mr1, ra1; logic [AW-1:0] ab0, ab1;
        apply_reset();
        fork
            access(0, 1'b1, 32'd1001425, 32'd25369366, a0, r0, d0, mb0, ab0, mr0, ra0);
            access(1, 1'b1, 32'd1001425, 32'd14528, a1, r1, d1, mb1, ab1, mr1, ra1);
        join
        checks++; if (!(a0 >= 0 && a1 > a0)) begin errors++; $display("FAIL sim_order: got acc0=%0d acc1=%0d expected acc0<acc1", a0, a1); end
        checks++; if (a1 - a0 !== LAT + 2) begin errors++; $display("FAIL sim_gap: got %0d expected %0d", a1 - a0, LAT + 2); end
        checks++; if (d0 !== 32'd25369366 || d1 !== 32'd14528) begin errors++; $display("FAIL sim_echo: got %0d/%0d expected 25369366/14528", d0, d1); end
        access(0, 1'b0, 32'd1001425, 32'd0, a0, r0, d0, mb0, ab0, mr0, ra0);
        checks++; if (d0 !== 32'd14528) begin errors++; $display("FAIL sim_readback: got %0d expected 14528", d0); end
    endtask

    task automatic test_back_to_back();
        int owners[$]; int times[$]; logic [1:0] rdy;
        apply_reset();
        @(negedge clk);
        req_mode = 2'b00;
        req_addr = {32'd2816867292, 32'd0};
        req_valid = 2'b11;
        for (int k = 0; k < 100 && owners.size() < 8; k++) begin
            #1;
            rdy = req_ready;
            checks++; if (rdy === 2'b11) begin errors++; $display("FAIL b2b_ready_onehot: got %b expected not 11", rdy); end
            if (rdy != 2'b00) begin
                owners.push_back(rdy[1] ? 1 : 0);
                times.push_back(cyc);
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        checks++; if (owners.size() !== 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", owners.size()); end
        foreach (owners[k]) begin
            checks++; if (owners[k] !== k % 2) begin errors++; $display("FAIL b2b_owner[%0d]: got %0d expected %0d", k, owners[k], k % 2); end
            if (k > 0) begin
                checks++; if (times[k] - times[k-1] < LAT + 2) begin
                    errors++; $display("FAIL b2b_gap[%0d]: got %0d expected >=%0d", k, times[k] - times[k-1], LAT + 2); end
            end
        end
        repeat (LAT + 3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] wd;
        wd = 32'hA5A5_0007;
        @(negedge clk);
        req_mode[0] = 1'b1;
        req_addr[AW-1:0] = 32'd7;
        req_data[DW-1:0] = wd;
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_accept: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        refmem[7] = wd;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 2'b00 || rsp_data !== '0) begin
            errors++; $display("FAIL mid_rsp_cleared: got v=%b d=%h expected 00/0", rsp_valid, rsp_data); end
        checks++; if (mem_address !== '0 || mem_data !== '0 || mem_mode !== 1'b0) begin
            errors++; $display("FAIL mid_mem_cleared: got addr=%h data=%h mode=%b expected 0/0/0", mem_address, mem_data, mem_mode); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < LAT + 3; k++) begin
            checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL mid_no_rsp[%0d]: got %b expected 00", k, rsp_valid); end
            @(negedge clk);
        end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_first_tie: got %b expected 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_random();
        int n, idle_at, pend_n, last; bit pend, pend_own, g;
        logic [DW-1:0] pend_data; logic [1:0] exp_rv, exp_rdy; logic [15:0] c0, c1;
        logic [AW-1:0] a0, a1;
        apply_reset();
        last = 1; idle_at = 0; pend = 1'b0; pend_n = 0; pend_own = 1'b0; pend_data = '0;
        c0 = 16'd0; c1 = 16'd0;
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            n = cyc;
            checks++; if (stat_cnt0 !== (STATS ? c0 : 16'd0) || stat_cnt1 !== (STATS ? c1 : 16'd0)) begin
                errors++; $display("FAIL rnd_stats@%0d: got %0d/%0d expected %0d/%0d", n, stat_cnt0, stat_cnt1,
                                    STATS ? c0 : 16'd0, STATS ? c1 : 16'd0); end
            exp_rv = (pend && n == pend_n) ? (pend_own ? 2'b10 : 2'b01) : 2'b00;
            checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rnd_rsp_valid@%0d: got %b expected %b", n, rsp_valid, exp_rv); end
            if (exp_rv != 2'b00) begin
                checks++; if (rsp_data !== pend_data) begin errors++; $display("FAIL rnd_rsp_data@%0d: got %h expected %h", n, rsp_data, pend_data); end
                pend = 1'b0;
                if (pend_own) c1 = c1 + 16'd1; else c0 = c0 + 16'd1;
            end
            a0 = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 7));
            a1 = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 7));
            req_valid = 2'($urandom_range(0, 3));
            req_mode  = 2'($urandom_range(0, 3));
            req_addr  = {a1, a0};
            req_data  = {$urandom, $urandom};
            #1;
            exp_rdy = 2'b00;
            if (n >= idle_at) begin
                if (req_valid == 2'b11) exp_rdy = (last == 1) ? 2'b01 : 2'b10;
                else exp_rdy = req_valid;
            end
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", n, req_ready, exp_rdy); end
            if (exp_rdy != 2'b00) begin
                g = exp_rdy[1];
                last = g ? 1 : 0;
                pend = 1'b1;
                pend_own = g;
                pend_n = n + 1 + LAT;
                if (req_mode[g]) begin
                    pend_data = req_data[g*DW +: DW];
                    refmem[req_addr[g*AW +: 12]] = req_data[g*DW +: DW];
                end else begin
                    pend_data = refmem[req_addr[g*AW +: 12]];
                end
                idle_at = n + LAT + 2;
            end
        end
        @(negedge clk);
        req_valid = 2'b00;
        repeat (LAT + 3) @(negedge clk);
    endtask

    task automatic test_stats();
        int a, r; logic [DW-1:0] rd; logic mb, mr, ra; logic [AW-1:0] ab;
        apply_reset();
        for (int k = 0; k < 5; k++) access(0, 1'b0, 32'(k), 32'd0, a, r, rd, mb, ab, mr, ra);
        for (int k = 0; k < 3; k++) access(1, 1'b0, 32'(k), 32'd0, a, r, rd, mb, ab, mr, ra);
        checks++; if (stat_cnt0 !== (STATS ? 16'd5 : 16'd0)) begin
            errors++; $display("FAIL stats_cnt0: got %0d expected %0d", stat_cnt0, STATS ? 5 : 0); end
        checks++; if (stat_cnt1 !== (STATS ? 16'd3 : 16'd0)) begin
            errors++; $display("FAIL stats_cnt1: got %0d expected %0d", stat_cnt1, STATS ? 3 : 0); end
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) refmem[k] = '0;
        #2;
        test_reset();
        test_write_read();
        test_wide_addr();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Two-requester round-robin arbiter and sequencer for the single-port `cache_and_ram` block. It accepts read/write requests from two independent masters over valid/ready handshakes and serialises them onto the shared `address`/`data`/`mode` port. It holds each request stable for a fixed memory latency, captures `out`, and returns a one-cycle response to the owning requester. It sits between the masters and the `cache_and_ram` instance.

## Interface
Parameters:
- ADDR_W, 32, address width, passed to memory unchanged; the memory applies its own modulo-4096 indexing.
- DATA_W, 32, data width.
- MEM_LAT, 2, clock edges after `mem_*` become valid before `mem_out` may be sampled; legal range 1–15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  request valid per requester; bit i = requester i.
- req_mode  in  2  per requester; 1 = write, 0 = read.
- req_addr  in  2×ADDR_W  packed; requester i in [i*ADDR_W +: ADDR_W].
- req_data  in  2×DATA_W  packed write data.
- req_ready  out  2  combinational accept, one-hot or zero.
- rsp_valid  out  2  one-cycle response strobe, one-hot or zero.
- rsp_data  out  DATA_W  read data, or echoed write data for writes.
- mem_address  out  ADDR_W  to `cache_and_ram.address`.
- mem_data  out  DATA_W  to `cache_and_ram.data`.
- mem_mode  out  1  to `cache_and_ram.mode`.
- mem_out  in  DATA_W  from `cache_and_ram.out`.
- stat_cnt0, stat_cnt1  out  16  completed-access counters (see Configuration).

## Operation
- FSM states:
  - IDLE → BUSY on accept.
  - BUSY → RESP when the latency counter expires.
  - RESP → IDLE unconditionally.
- Grant rule in IDLE:
  - If only one `req_valid` bit is set, that requester is granted.
  - If both are set, the requester ≠ `last_owner` is granted.
  - `last_owner` resets to 1, so requester 0 wins the first tie.
- `req_ready[i]` = (state == IDLE) && granted(i); zero in BUSY and RESP.
- On the accept edge:
  - Register the granted request into `mem_address`/`mem_data`/`mem_mode`.
  - Set `owner` and `last_owner` to i.
  - Load `cnt` = MEM_LAT.
- BUSY:
  - `mem_*` are held stable.
  - `cnt` decrements each edge.
  - At the edge where `cnt` == 1:
    - Read: `rsp_data` ← `mem_out`.
    - Write: `rsp_data` ← `mem_data`.
    - Assert `rsp_valid[owner]`, go to RESP.
- RESP:
  - `rsp_valid` is high for exactly this cycle.
  - Next edge: clear `rsp_valid`, return to IDLE.
  - `mem_mode` drops to 0 (read) so no stray write is repeated.
  - `mem_address`/`mem_data` keep their last values.
- Requester deasserting `req_valid` while not accepted: legal; no side effects.
- Changing request fields after acceptance has no effect.
- Reset (asynchronous, at any time, including mid-access):
  - State IDLE; `cnt`, `req_ready`, `rsp_valid`, `rsp_data`, `mem_address`, `mem_data`, `mem_mode`, stats all 0.
  - `last_owner` = 1.
  - An in-flight access is abandoned with no response; a write may already have reached memory.

## Timing
- Accept at edge E0.
- `mem_*` valid after E0.
- `mem_out` sampled at edge E0+MEM_LAT.
- `rsp_valid` high from E0+MEM_LAT to E0+MEM_LAT+1.
- Next accept no earlier than E0+MEM_LAT+2.
- Throughput: one access per MEM_LAT+2 cycles (4 at default).
- Both masters continuously valid: grants alternate 0,1,0,1…

## Configuration
- Macro `CACHE_ARB_STATS_EN`.
- Defined:
  - `stat_cnt0`/`stat_cnt1` increment by 1 on each `rsp_valid` of the matching requester.
  - Counters wrap from 16'hFFFF to 0 and clear on reset.
- Undefined:
  - Counter logic is not compiled; both ports are tied to 0.
- Arbitration and timing are identical in both builds.

## Test plan
- Write, then read back: req0 writes 14528 to address 0, then reads address 0 → `rsp_valid[0]` at E0+2, `rsp_data` = 14528; `mem_mode` = 1 only during the write's BUSY.
- Wide address pass-through: req1 writes 526421 to address 2816867292 (memory index 3036), then reads it → `mem_address` = 2816867292 exactly; read `rsp_data` = 526421.
- Simultaneous requests: both valid from reset, req0 writing 25369366 to 1001425 and req1 writing 14528 to 1001425 → req0 granted first, req1 second; subsequent read returns 14528.
- Back-to-back contention: hold both valid for 8 accesses → grants strictly alternate; a new accept never occurs less than 4 cycles after the previous one; `req_ready` is never 2'b11.
- Reset mid-access: assert `rst` one cycle after accept → all outputs 0 immediately; no `rsp_valid`; the first post-reset tie goes to req0.
- Stats build: with `CACHE_ARB_STATS_EN`, 5 req0 accesses and 3 req1 accesses → `stat_cnt0` = 5, `stat_cnt1` = 3; without the macro, both counters read 0.
